core_scheduler: RTL and testbench

Sequential dispatcher sitting between the event queue and the simulation cores, and the producer of every input of the `gvtmonitor` block. It hands the head-of-queue event to an idle core chosen round-robin, and tracks each core's busy flag and in-flight timestamp. It throttles dispatch to a lookahead window above the current GVT and flags simulation completion once the queue head passes the end time with all cores idle.

---
 rtl/pdes_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/core_scheduler.sv | 108 ++++++++++
 tb/tb_core_scheduler.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdes_pkg.sv
// Shared types and helpers for the PDES scheduling blocks.
// Holds the timestamp width, the scheduler state encoding and the lookahead-window compare.
package pdes_pkg;

    localparam int TIME_WID = 16;
    localparam logic [TIME_WID-1:0] TIME_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ISSUE,
        DONE
    } sched_state_t;

    // The limit is one bit wider than a timestamp, so gvt near TIME_MAX cannot wrap it.
    function automatic logic in_window(
        input logic [TIME_WID-1:0] evt_t,
        input logic [TIME_WID-1:0] gvt_t,
        input logic [TIME_WID-1:0] window
    );
        logic [TIME_WID:0] limit;
        limit = {1'b0, gvt_t} + {1'b0, window};
        return ({1'b0, evt_t} <= limit);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick of the first idle core at or after the pointer.
// Wraps modulo NUM_CORE; any_grant is low when no core is idle.
module rr_arbiter #(
    parameter int NUM_CORE = 8,
    parameter int CORE_WID = 3
) (
    input  logic [NUM_CORE-1:0] idle,
    input  logic [CORE_WID-1:0] ptr,
    output logic [CORE_WID-1:0] grant,
    output logic                any_grant
);

    logic [CORE_WID-1:0] cand;

    // Scan from the farthest offset down so the nearest idle core wins last.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int i = NUM_CORE - 1; i >= 0; i--) begin
            cand = CORE_WID'((int'(ptr) + i) % NUM_CORE);
            if (idle[cand]) begin
                grant     = cand;
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_scheduler.sv
// Dispatches queue-head events to idle cores round-robin, within a lookahead window above GVT.
// Tracks per-core busy flags and in-flight timestamps, and raises sim_done once the run drains.
module core_scheduler
    import pdes_pkg::*;
#(
    parameter int                  NUM_CORE = 8,
    parameter int                  CORE_WID = 3,
    parameter logic [TIME_WID-1:0] WINDOW   = 16'h0010
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [TIME_WID-1:0]          end_time,
    input  logic                         evt_vld,
    input  logic [TIME_WID-1:0]          evt_time,
    output logic                         evt_pop,
    output logic                         disp_vld,
    output logic [CORE_WID-1:0]          disp_core,
    output logic [TIME_WID-1:0]          disp_time,
    input  logic                         disp_rdy,
    input  logic [NUM_CORE-1:0]          core_done,
    input  logic [TIME_WID-1:0]          gvt,
    output logic [TIME_WID*NUM_CORE-1:0] core_times,
    output logic [NUM_CORE-1:0]          core_vld,
    output logic [TIME_WID-1:0]          next_event,
    output logic                         sim_done
);

    sched_state_t        state, state_next;
    logic [TIME_WID-1:0] end_time_q;
    logic [CORE_WID-1:0] rr_ptr;
    logic [CORE_WID-1:0] grant;
    logic                any_idle;
    logic                before_end;
    logic                can_issue;
    logic                accept;
    logic [NUM_CORE-1:0] grant_mask;
    logic [TIME_WID-1:0] times_q [NUM_CORE];

    rr_arbiter #(
        .NUM_CORE (NUM_CORE),
        .CORE_WID (CORE_WID)
    ) u_arbiter (
        .idle      (~core_vld),
        .ptr       (rr_ptr),
        .grant     (grant),
        .any_grant (any_idle)
    );

    assign next_event = evt_vld ? evt_time : TIME_MAX;
    assign before_end = (evt_time < end_time_q);
    assign can_issue  = evt_vld && before_end && any_idle && in_window(evt_time, gvt, WINDOW);
    assign disp_vld   = (state == ISSUE);
    assign accept     = disp_vld && disp_rdy;
    assign evt_pop    = accept;
    assign grant_mask = accept ? ({{(NUM_CORE-1){1'b0}}, 1'b1} << disp_core) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = RUN;
            RUN: begin
                if (can_issue)
                    state_next = ISSUE;
                else if ((core_vld == '0) && (!evt_vld || !before_end))
                    state_next = DONE;
            end
            ISSUE: if (disp_rdy) state_next = RUN;
            DONE:  state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            end_time_q <= '0;
            rr_ptr     <= '0;
            disp_core  <= '0;
            disp_time  <= '0;
            core_vld   <= '0;
            sim_done   <= 1'b0;
            for (int i = 0; i < NUM_CORE; i++) times_q[i] <= '0;
        end else begin
            if ((state == IDLE) && start) end_time_q <= end_time;
            if ((state == RUN) && can_issue) begin
                disp_core <= grant;
                disp_time <= evt_time;
            end
            if (accept) begin
                times_q[disp_core] <= disp_time;
                rr_ptr <= (disp_core == CORE_WID'(NUM_CORE - 1)) ? '0 : disp_core + 1'b1;
            end
            // A release and a grant on different cores in the same cycle both take effect.
            core_vld <= (core_vld & ~core_done) | grant_mask;
            if (state_next == DONE) sim_done <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CORE; i++) begin : g_times
        assign core_times[TIME_WID*i +: TIME_WID] = times_q[i];
    end

endmodule

// File: tb/tb_core_scheduler.sv
// Self-checking bench for core_scheduler: a transaction-level model of the dispatcher is
// compared every cycle, plus directed scenarios pinned with literal expectations.
module tb_core_scheduler;

    localparam int NC = 8;
    localparam int TW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [TW-1:0]     end_time = '0;
    logic              evt_vld = 1'b0;
    logic [TW-1:0]     evt_time = '0;
    logic              evt_pop;
    logic              disp_vld;
    logic [2:0]        disp_core;
    logic [TW-1:0]     disp_time;
    logic              disp_rdy = 1'b0;
    logic [NC-1:0]     core_done = '0;
    logic [TW-1:0]     gvt = '0;
    logic [TW*NC-1:0]  core_times;
    logic [NC-1:0]     core_vld;
    logic [TW-1:0]     next_event;
    logic              sim_done;

    core_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .end_time   (end_time),
        .evt_vld    (evt_vld),
        .evt_time   (evt_time),
        .evt_pop    (evt_pop),
        .disp_vld   (disp_vld),
        .disp_core  (disp_core),
        .disp_time  (disp_time),
        .disp_rdy   (disp_rdy),
        .core_done  (core_done),
        .gvt        (gvt),
        .core_times (core_times),
        .core_vld   (core_vld),
        .next_event (next_event),
        .sim_done   (sim_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pop_count = 0;
    bit pop_seen = 1'b0;
    logic [TW-1:0] q[$];

    // Reference model: phase 0 waiting, 1 choosing, 2 offering, 3 finished.
    int            m_phase;
    bit            m_busy [NC];
    logic [TW-1:0] m_time [NC];
    int            m_ptr;
    int            m_core;
    logic [TW-1:0] m_dtime;
    logic [TW-1:0] m_end;
    bit            m_done;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void drive_evt();
        evt_vld  = (q.size() > 0);
        evt_time = (q.size() > 0) ? q[0] : 16'h0;
    endfunction

    // Advance one clock; inputs always change 1 time unit after the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (pop_seen && q.size() > 0) void'(q.pop_front());
        pop_seen  = 1'b0;
        start     = 1'b0;
        core_done = '0;
        drive_evt();
    endtask

    task automatic model_reset();
        m_phase = 0;
        for (int i = 0; i < NC; i++) begin
            m_busy[i] = 1'b0;
            m_time[i] = '0;
        end
        m_ptr = 0;
        m_core = 0;
        m_dtime = '0;
        m_end = '0;
        m_done = 1'b0;
    endtask

    task automatic model_step();
        int  nphase;
        bit  found;
        int  pick;
        int  nbusy;
        bit  win;
        nphase = m_phase;
        found  = 1'b0;
        pick   = 0;
        nbusy  = 0;
        for (int i = 0; i < NC; i++) nbusy += m_busy[i];
        win = (int'(evt_time) <= int'(gvt) + 16);
        for (int k = 0; k < NC; k++) begin
            if (!found && !m_busy[(m_ptr + k) % NC]) begin
                found = 1'b1;
                pick  = (m_ptr + k) % NC;
            end
        end
        case (m_phase)
            0: if (start) begin nphase = 1; m_end = end_time; end
            1: begin
                if (evt_vld && evt_time < m_end && found && win) begin
                    nphase  = 2;
                    m_core  = pick;
                    m_dtime = evt_time;
                end else if (nbusy == 0 && (!evt_vld || evt_time >= m_end)) begin
                    nphase = 3;
                    m_done = 1'b1;
                end
            end
            default: ;
        endcase
        for (int i = 0; i < NC; i++) if (core_done[i]) m_busy[i] = 1'b0;
        if (m_phase == 2 && disp_rdy) begin
            m_busy[m_core] = 1'b1;
            m_time[m_core] = m_dtime;
            m_ptr  = (m_core + 1) % NC;
            nphase = 1;
        end
        m_phase = nphase;
    endtask

    // Compare process: every falling edge, outputs against the model, then advance the model.
    always @(negedge clk) begin
        logic [TW*NC-1:0] exp_times;
        logic [NC-1:0]    exp_vld;
        if (!rst_n) model_reset();
        for (int i = 0; i < NC; i++) begin
            exp_times[TW*i +: TW] = m_time[i];
            exp_vld[i] = m_busy[i];
        end
        checkOutput("disp_vld", disp_vld, m_phase == 2);
        if (m_phase == 2) begin
            checkOutput("disp_core", disp_core, m_core);
            checkOutput("disp_time", disp_time, m_dtime);
        end
        checkOutput("evt_pop", evt_pop, (m_phase == 2) && disp_rdy);
        checkOutput("core_vld", core_vld, exp_vld);
        checkOutput("core_times", core_times, exp_times);
        checkOutput("sim_done", sim_done, m_done);
        checkOutput("next_event", next_event, evt_vld ? evt_time : 16'hFFFF);
        pop_seen = evt_pop;
        if (evt_pop) pop_count++;
        if (rst_n) model_step();
    end

    task automatic wait_dispatch(output int core, output logic [TW-1:0] t);
        bit got;
        got  = 1'b0;
        core = -1;
        t    = '1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            #1;
            if (evt_pop) begin
                got  = 1'b1;
                core = disp_core;
                t    = disp_time;
            end
            applyStimulus();
        end
        checkOutput("dispatch_timeout", got, 1'b1);
    endtask

    task automatic wait_issue();
        bit got;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            #1;
            if (disp_vld) got = 1'b1;
            else applyStimulus();
        end
        checkOutput("issue_timeout", got, 1'b1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            c;
        int            c0;
        int            pops;
        bit            got;
        logic [TW-1:0] t;
        logic [TW-1:0] t0;

        drive_evt();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("rst_disp_vld", disp_vld, 1'b0);
        checkOutput("rst_evt_pop", evt_pop, 1'b0);
        checkOutput("rst_disp_core", disp_core, 3'd0);
        checkOutput("rst_disp_time", disp_time, 16'h0);
        checkOutput("rst_core_vld", core_vld, 8'h00);
        checkOutput("rst_core_times", core_times, 128'h0);
        checkOutput("rst_sim_done", sim_done, 1'b0);
        checkOutput("rst_next_event", next_event, 16'hFFFF);

        // First dispatch from a fresh start.
        applyStimulus();
        end_time = 16'h100;
        gvt      = 16'h0;
        disp_rdy = 1'b1;
        q.push_back(16'h05);
        drive_evt();
        start = 1'b1;
        wait_dispatch(c, t);
        checkOutput("first_core", c, 0);
        checkOutput("first_time", t, 16'h05);
        @(negedge clk);
        #1;
        checkOutput("first_core_vld", core_vld, 8'h01);
        checkOutput("first_slot0", core_times[15:0], 16'h05);
        checkOutput("first_single_pop", pop_count, 1);

        // Seven more events fill cores 1..7 in order, then a ninth stalls.
        applyStimulus();
        for (int e = 1; e < NC; e++) q.push_back(16'(5 + e));
        drive_evt();
        for (int e = 1; e < NC; e++) begin
            wait_dispatch(c, t);
            checkOutput("rr_order", c, e);
        end
        q.push_back(16'h0E);
        drive_evt();
        pops = pop_count;
        repeat (8) applyStimulus();
        @(negedge clk);
        #1;
        checkOutput("stall_no_pop", pop_count - pops, 0);
        checkOutput("stall_all_busy", core_vld, 8'hFF);
        applyStimulus();
        core_done = 8'h08;
        wait_dispatch(c, t);
        checkOutput("freed_core3", c, 3);

        // Lookahead window: 0x21 is outside gvt 0x10 + 0x10, 0x20 is inside.
        core_done = 8'hFF;
        gvt = 16'h10;
        q.push_back(16'h21);
        drive_evt();
        pops = pop_count;
        repeat (6) applyStimulus();
        @(negedge clk);
        #1;
        checkOutput("window_block_pop", pop_count - pops, 0);
        checkOutput("window_block_vld", disp_vld, 1'b0);
        applyStimulus();
        q[0] = 16'h20;
        drive_evt();
        wait_dispatch(c, t);
        checkOutput("window_edge_time", t, 16'h20);
        gvt = 16'hFFF8;
        q.push_back(16'h30);
        drive_evt();
        wait_dispatch(c, t);
        checkOutput("window_nowrap_time", t, 16'h30);

        // Back-pressure: disp_rdy low holds the offer stable with no pop.
        disp_rdy = 1'b0;
        q.push_back(16'h31);
        drive_evt();
        wait_issue();
        c0 = disp_core;
        t0 = disp_time;
        pops = pop_count;
        for (int k = 0; k < 4; k++) begin
            applyStimulus();
            @(negedge clk);
            #1;
            checkOutput("hold_vld", disp_vld, 1'b1);
            checkOutput("hold_core", disp_core, c0);
            checkOutput("hold_time", disp_time, 16'h31);
        end
        checkOutput("hold_time_first", t0, 16'h31);
        checkOutput("hold_no_pop", pop_count - pops, 0);
        applyStimulus();
        disp_rdy = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("accept_pop", evt_pop, 1'b1);
        applyStimulus();
        checkOutput("accept_single_pop", pop_count - pops, 1);

        // Reset in the middle of an offer drops it at once.
        disp_rdy = 1'b0;
        q.push_back(16'h32);
        drive_evt();
        wait_issue();
        applyStimulus();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_vld", disp_vld, 1'b0);
        checkOutput("rst_mid_pop", evt_pop, 1'b0);
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();
        end_time = 16'h100;
        gvt      = 16'h30;
        disp_rdy = 1'b1;
        start    = 1'b1;
        wait_dispatch(c, t);
        checkOutput("restart_core", c, 0);
        checkOutput("restart_time", t, 16'h32);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int n = 0; n < 400; n++) begin
            applyStimulus();
            disp_rdy  = ($urandom_range(0, 3) != 0);
            core_done = NC'($urandom & $urandom);
            if ($urandom_range(0, 15) == 0) gvt = 16'($urandom_range(0, 16'hF0));
            if (q.size() < 3) q.push_back(16'($urandom_range(0, 16'hFF)));
            drive_evt();
        end

        // Drain to an event at end_time with all cores idle.
        applyStimulus();
        disp_rdy = 1'b1;
        gvt = 16'h00F0;
        q.push_back(16'h100);
        drive_evt();
        got = 1'b0;
        for (int n = 0; n < 300 && !got; n++) begin
            applyStimulus();
            core_done = 8'hFF;
            @(negedge clk);
            #1;
            if (sim_done) got = 1'b1;
        end
        checkOutput("done_reached", got, 1'b1);
        checkOutput("done_head_kept", next_event, 16'h100);
        checkOutput("done_cores_idle", core_vld, 8'h00);
        applyStimulus();
        start = 1'b1;
        pops = pop_count;
        repeat (5) applyStimulus();
        @(negedge clk);
        #1;
        checkOutput("done_sticky", sim_done, 1'b1);
        checkOutput("done_start_ignored", disp_vld, 1'b0);
        checkOutput("done_no_pop", pop_count - pops, 0);
        applyStimulus();
        rst_n = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
        q.delete();
        q.push_back(16'h05);
        drive_evt();
        repeat (4) applyStimulus();
        @(negedge clk);
        #1;
        checkOutput("post_rst_done", sim_done, 1'b0);
        checkOutput("post_rst_idle", disp_vld, 1'b0);
        checkOutput("post_rst_no_pop", pop_count - pops, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
